// File: rtl/countdown_timer_if.sv
// Control and status bundle for countdown_timer: the master drives commands,
// the slave (the timer) returns count and status.
interface countdown_timer_if #(
  parameter int unsigned WIDTH = 8
);
  logic             en;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             start;
  logic             stop;
  logic             periodic;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             expired;
  logic             done;

  modport master (
    output en, load, load_val, start, stop, periodic,
    input  count, busy, expired, done
  );

  modport slave (
    input  en, load, load_val, start, stop, periodic,
    output count, busy, expired, done
  );
endinterface

// File: rtl/countdown_timer.sv
// Loadable down-counting timer with one-shot/periodic modes and an en-qualified
// prescaler; all outputs come straight from registers.
module countdown_timer #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned PRESCALE = 1
) (
  input  logic              clk,
  input  logic              rst,
  countdown_timer_if.slave  bus
);
  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic             busy_q, busy_d;
  logic             expired_q, expired_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] eff_reload;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      reload_q  <= '0;
      count_q   <= '0;
      pre_q     <= '0;
      busy_q    <= 1'b0;
      expired_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      reload_q  <= reload_d;
      count_q   <= count_d;
      pre_q     <= pre_d;
      busy_q    <= busy_d;
      expired_q <= expired_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    reload_d   = reload_q;
    count_d    = count_q;
    pre_d      = pre_q;
    expired_d  = 1'b0;
    done_d     = done_q;
    eff_reload = bus.load ? bus.load_val : reload_q;

    if (bus.stop && state_q == RUN) begin
      state_d = IDLE;
      pre_d   = '0;
    end else if (bus.start && eff_reload != '0) begin
      reload_d = eff_reload;
      count_d  = eff_reload;
      pre_d    = '0;
      done_d   = 1'b0;
      state_d  = RUN;
    end else begin
      // A load while running only retargets the next reload; the tick still proceeds.
      if (bus.load) begin
        reload_d = bus.load_val;
        if (state_q != RUN) begin
          count_d = bus.load_val;
          done_d  = 1'b0;
        end
      end
      if (state_q == RUN && bus.en) begin
        if (pre_q == PW'(PRESCALE - 1)) begin
          pre_d = '0;
          if (count_q == WIDTH'(1)) begin
            expired_d = 1'b1;
            if (bus.periodic) begin
              count_d = reload_q;
            end else begin
              count_d = '0;
              state_d = DONE;
              done_d  = 1'b1;
            end
          end else begin
            count_d = count_q - WIDTH'(1);
          end
        end else begin
          pre_d = pre_q + PW'(1);
        end
      end
    end

    busy_d = (state_d == RUN);
  end

  assign bus.count   = count_q;
  assign bus.busy    = busy_q;
  assign bus.expired = expired_q;
  assign bus.done    = done_q;
endmodule
